muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide instructions (funct7 = 0000001) in the EX stage.
- Accepts one operation from EX and iterates it over XLEN cycles with a shared shift-add/restore-subtract datapath.
- Holds the pipeline through a stall output and returns a registered result with a one-cycle done pulse.
- The ALU decoder continues to handle all non-M operations; this block runs beside it.

---
 rtl/muldiv_sequencer.sv | 163 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: XLEN-cycle shift-add / restoring-divide, done pulse XLEN+2 cycles after accept (1 for div-by-zero/overflow).
// Holds the pipeline with a combinational stall; a start while busy is ignored, and flush abandons the op with the result left unchanged.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_div, a_signed, b_signed, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;
  logic [XLEN-1:0] mul_addend;
  logic [XLEN:0]   mul_sum, div_trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_res;

  // Operand decode for the op presented by EX.
  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    abs_a    = (a_signed && srca[XLEN-1]) ? -srca : srca;
    abs_b    = (b_signed && srcb[XLEN-1]) ? -srcb : srcb;
    div_zero = is_div && (srcb == '0);
    div_ovf  = is_div && !funct3[0] && (srca == MIN_NEG) && (srcb == '1);
    if (div_zero) fast_res = funct3[1] ? srca : '1;
    else          fast_res = funct3[1] ? '0 : srca;
  end

  // hi/lo hold {product} for multiply and {remainder, quotient} for divide;
  // opnd holds the multiplicand or the divisor.
  always_comb begin
    mul_addend = lo_q[0] ? opnd_q : '0;
    mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
    div_trial  = {hi_q, lo_q[XLEN-1]} - {1'b0, opnd_q};
    prod_fix   = (sign_a_q ^ sign_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot_fix   = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem_fix    = sign_a_q ? -hi_q : hi_q;
    case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d     = funct3;
          sign_a_d = a_signed && srca[XLEN-1];
          sign_b_d = b_signed && srcb[XLEN-1];
          cnt_d    = '0;
          hi_d     = '0;
          lo_d     = is_div ? abs_a : abs_b;
          opnd_d   = is_div ? abs_b : abs_a;
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_ONE;
        if (op_q[2]) begin
          if (!div_trial[XLEN]) begin
            hi_d = div_trial[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_LAST) state_d = FIXUP;
      end
      FIXUP: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flushed op never lands its result, even from FIXUP.
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

  assign stall  = ((state_q == IDLE) && start && !flush) ||
                  (state_q == CALC) || (state_q == FIXUP);
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized checks of muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] srca, srcb;
  logic        stall, busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .srca   (srca),
    .srcb   (srcb),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f3)
      3'd0: begin p = ua * ub;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one op, holds/toggles start and scrambles operands while busy,
  // and keeps start high through the DONE edge to show it is not accepted there.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat, cyc;
    bit seen, stall_ok;
    lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
    @(negedge clk);
    start = 1'b1; funct3 = f3; srca = a; srcb = b;
    #1 check({tag, " stall@accept"}, 64'(stall), 64'd1);
    cyc = 0; seen = 0; stall_ok = 1;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        seen = 1;
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " result"}, 64'(result), 64'(exp));
        check({tag, " stall@done"}, 64'(stall), 64'd0);
        start = 1'b1;
      end else begin
        if (stall !== 1'b1) stall_ok = 0;
        start = 1'($urandom);
      end
      srca = $urandom; srcb = $urandom; funct3 = 3'($urandom);
    end
    check({tag, " done seen"}, 64'(seen), 64'd1);
    check({tag, " stall while busy"}, 64'(stall_ok), 64'd1);
    @(negedge clk);
    check({tag, " busy after done"}, {63'd0, busy}, 64'd0);
    check({tag, " single done"}, {63'd0, done}, 64'd0);
    check({tag, " result held"}, 64'(result), 64'(exp));
    start = 1'b0;
    #1 check({tag, " stall idle"}, 64'(stall), 64'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit          got_done;

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; srca = '0; srcb = '0;
    repeat (3) @(negedge clk);
    check("reset busy",   {63'd0, busy},  64'd0);
    check("reset done",   {63'd0, done},  64'd0);
    check("reset stall",  {63'd0, stall}, 64'd0);
    check("reset result", 64'(result),    64'd0);
    rst = 1'b0;

    run_op("MUL 7*-3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("MULH min*min",  3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    run_op("MULHU ones",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("MULHSU ones",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("DIV -7/2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    run_op("REM -7/2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    run_op("DIVU 100/7",    3'd5, 32'd100,        32'd7,         32'd14);
    run_op("REMU 100/7",    3'd7, 32'd100,        32'd7,         32'd2);
    run_op("DIVU 5/0",      3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF);
    run_op("REMU 5/0",      3'd7, 32'd5,          32'd0,         32'd5);
    run_op("REM ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
    run_op("DIV ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);

    // Flush at cycle 10 of a MUL.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; srca = 32'd12345; srcb = 32'd678;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush busy",   {63'd0, busy}, 64'd0);
    check("flush done",   {63'd0, done}, 64'd0);
    check("flush result", 64'(result),   64'h8000_0000);
    got_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) got_done = 1;
    end
    check("flush no late done", 64'(got_done), 64'd0);
    check("flush result kept",  64'(result),   64'h8000_0000);

    run_op("DIVU 9/3", 3'd5, 32'd9, 32'd3, 32'd3);

    // flush wins over start in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd5; srca = 32'd8; srcb = 32'd0;
    #1 check("flush+start stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    check("flush+start busy", {63'd0, busy}, 64'd0);
    check("flush+start done", {63'd0, done}, 64'd0);
    start = 1'b0; flush = 1'b0;

    // Reset at cycle 5 of a DIV.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; srca = 32'hFFFF_FFF9; srcb = 32'd2;
    repeat (5) @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst mid busy",   {63'd0, busy},  64'd0);
    check("rst mid result", 64'(result),    64'd0);
    check("rst mid stall",  {63'd0, stall}, 64'd0);
    check("rst mid done",   {63'd0, done},  64'd0);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = 32'd0; end
        2: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(0, 20)) - 32'd10; end
        default: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      endcase
      run_op("random", f3, a, b, ref_model(f3, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
